// File: rtl/z80_bus_pkg.sv
// Shared types and constants for the Z80 I/O bridge: FSM states, latched request
// payload and the open-bus default.
package z80_bus_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned CNT_W  = 8;

  localparam logic [DATA_W-1:0] OPEN_BUS_DEFAULT = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_REQ      = 2'd1,
    ST_WAIT_RDY = 2'd2,
    ST_HOLD     = 2'd3
  } io_state_e;

  typedef struct packed {
    logic [DATA_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } io_req_t;

  // A bus cycle starts on the registered-high to current-low transition of iorq_n.
  function automatic logic iorq_fell(input logic prev, input logic cur);
    return prev & ~cur;
  endfunction

endpackage

// File: rtl/z80_io_timeout.sv
// Wait-state limiter: counts cen ticks spent waiting for io_rdy and flags the
// tick on which the TIMEOUT-th wait tick is reached.
module z80_io_timeout
  import z80_bus_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset_n,
  input  logic cen,
  input  logic clr,
  input  logic inc,
  output logic expire_c
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count <= '0;
    end else if (cen) begin
      if (clr) begin
        count <= '0;
      end else if (inc) begin
        count <= count + CNT_W'(1);
      end
    end
  end

  // The incrementing tick that would make the count equal TIMEOUT ends the wait.
  assign expire_c = inc && (count == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/z80_io_bridge.sv
// Z80 I/O bus bridge: turns CPU IN/OUT cycles into single-tick peripheral strobes,
// inserts wait states and serves interrupt acknowledge. Optional wait-state limit
// is built when IO_BRIDGE_TIMEOUT_EN is defined.
module z80_io_bridge
  import z80_bus_pkg::*;
#(
  parameter int unsigned       TIMEOUT  = 255,
  parameter logic [DATA_W-1:0] OPEN_BUS = OPEN_BUS_DEFAULT
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cen,
  input  logic              m1_n,
  input  logic              iorq_n,
  input  logic              rd_n,
  input  logic              wr_n,
  input  logic [15:0]       A,
  input  logic [DATA_W-1:0] cpu_dout,
  output logic [DATA_W-1:0] cpu_di,
  output logic              wait_n,
  output logic              int_n,
  output logic [DATA_W-1:0] io_addr,
  output logic [DATA_W-1:0] io_wdata,
  output logic              io_rd,
  output logic              io_wr,
  input  logic              io_rdy,
  input  logic [DATA_W-1:0] io_rdata,
  input  logic              int_req,
  input  logic [DATA_W-1:0] int_vec,
  output logic              inta
);

  io_state_e state;
  io_req_t   req;
  logic      iorq_prev;
  logic      rd_cycle;
  logic      fell_c;
  logic      tmo_c;
  logic      unused_addr;

  assign fell_c      = iorq_fell(iorq_prev, iorq_n);
  assign unused_addr = ^A[15:8];
  assign io_addr     = req.addr;
  assign io_wdata    = req.wdata;

  // Stall the CPU for the whole I/O cycle until the bridge reaches HOLD.
  assign wait_n = ~(~iorq_n & m1_n & (state != ST_HOLD));

`ifdef IO_BRIDGE_TIMEOUT_EN
  logic tmo_clr_c;
  logic tmo_inc_c;

  assign tmo_clr_c = (state != ST_WAIT_RDY);
  assign tmo_inc_c = (state == ST_WAIT_RDY) & ~iorq_n & ~io_rdy;

  z80_io_timeout #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk      (clk),
    .reset_n  (reset_n),
    .cen      (cen),
    .clr      (tmo_clr_c),
    .inc      (tmo_inc_c),
    .expire_c (tmo_c)
  );
`else
  logic unused_cfg;

  assign tmo_c      = 1'b0;
  assign unused_cfg = ^{8'(TIMEOUT), OPEN_BUS};
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      iorq_prev <= 1'b1;
      rd_cycle  <= 1'b0;
      cpu_di    <= '0;
      int_n     <= 1'b1;
      io_rd     <= 1'b0;
      io_wr     <= 1'b0;
      inta      <= 1'b0;
      req       <= '0;
    end else if (cen) begin
      iorq_prev <= iorq_n;
      int_n     <= ~int_req;
      io_rd     <= 1'b0;
      io_wr     <= 1'b0;
      inta      <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (fell_c) begin
            if (m1_n) begin
              // Strobes are raised here so they are high exactly during the REQ tick.
              state     <= ST_REQ;
              req.addr  <= A[7:0];
              req.wdata <= cpu_dout;
              io_wr     <= ~wr_n;
              io_rd     <= ~rd_n & wr_n;
              rd_cycle  <= ~rd_n & wr_n;
            end else begin
              inta   <= 1'b1;
              cpu_di <= int_vec;
            end
          end
        end
        ST_REQ, ST_WAIT_RDY: begin
          if (iorq_n) begin
            state <= ST_IDLE;
          end else if (io_rdy) begin
            state <= ST_HOLD;
            if (rd_cycle) begin
              cpu_di <= io_rdata;
            end
          end else if (tmo_c) begin
            state <= ST_HOLD;
            if (rd_cycle) begin
              cpu_di <= OPEN_BUS;
            end
          end else begin
            state <= ST_WAIT_RDY;
          end
        end
        ST_HOLD: begin
          if (iorq_n) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_z80_io_bridge.sv
// Bench for z80_io_bridge: transaction-level reference model checked every cycle,
// directed bus scenarios with literal expectations, then randomized bus traffic.
module tb_z80_io_bridge;

`ifdef IO_BRIDGE_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif
  localparam int unsigned TMO  = 4;
  localparam logic [7:0]  OPEN = 8'hFF;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cen = 1'b1;
  logic        m1_n = 1'b1, iorq_n = 1'b1, rd_n = 1'b1, wr_n = 1'b1;
  logic [15:0] A = '0;
  logic [7:0]  cpu_dout = '0;
  logic [7:0]  cpu_di;
  logic        wait_n, int_n;
  logic [7:0]  io_addr, io_wdata;
  logic        io_rd, io_wr, inta;
  logic        io_rdy = 1'b0;
  logic [7:0]  io_rdata = '0;
  logic        int_req = 1'b0;
  logic [7:0]  int_vec = '0;

  int vectors = 0;
  int miscompares = 0;

  z80_io_bridge #(.TIMEOUT(TMO), .OPEN_BUS(OPEN)) dut (
    .clk(clk), .reset_n(reset_n), .cen(cen), .m1_n(m1_n), .iorq_n(iorq_n),
    .rd_n(rd_n), .wr_n(wr_n), .A(A), .cpu_dout(cpu_dout), .cpu_di(cpu_di),
    .wait_n(wait_n), .int_n(int_n), .io_addr(io_addr), .io_wdata(io_wdata),
    .io_rd(io_rd), .io_wr(io_wr), .io_rdy(io_rdy), .io_rdata(io_rdata),
    .int_req(int_req), .int_vec(int_vec), .inta(inta)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a bus cycle is idle, strobed, waiting or done.
  typedef struct packed {
    logic [1:0] ph;       // 0 idle, 1 strobed, 2 waiting, 3 done
    logic       prev;
    logic [7:0] di;
    logic       int_n;
    logic       rd, wr, inta;
    logic [7:0] addr, wdata;
    logic       isrd;
    logic [8:0] waited;
  } model_t;

  model_t m;
  logic   started = 1'b0;

  function automatic model_t model_step(input model_t c);
    model_t n;
    logic   fell;
    n = c;
    fell = c.prev && !iorq_n;
    n.prev = iorq_n;
    n.int_n = !int_req;
    n.rd = 1'b0; n.wr = 1'b0; n.inta = 1'b0;
    if (c.ph == 2'd0) begin
      if (fell && m1_n) begin
        n.ph = 2'd1; n.addr = A[7:0]; n.wdata = cpu_dout; n.waited = '0;
        n.wr = !wr_n; n.rd = !rd_n && wr_n; n.isrd = !rd_n && wr_n;
      end else if (fell) begin
        n.inta = 1'b1; n.di = int_vec;
      end
    end else if (c.ph == 2'd3) begin
      if (iorq_n) n.ph = 2'd0;
    end else begin
      if (iorq_n) n.ph = 2'd0;
      else if (io_rdy) begin
        n.ph = 2'd3;
        if (c.isrd) n.di = io_rdata;
      end else if (c.ph == 2'd2 && TMO_EN && (int'(c.waited) + 1 >= int'(TMO))) begin
        n.ph = 2'd3;
        if (c.isrd) n.di = OPEN;
      end else begin
        if (c.ph == 2'd2) n.waited = c.waited + 9'd1;
        n.ph = 2'd2;
      end
    end
    return n;
  endfunction

  always @(posedge clk) begin
    if (!reset_n) begin
      m <= '{ph: 2'd0, prev: 1'b1, di: 8'h00, int_n: 1'b1, rd: 1'b0, wr: 1'b0,
             inta: 1'b0, addr: 8'h00, wdata: 8'h00, isrd: 1'b0, waited: 9'd0};
      started <= 1'b1;
    end else if (cen) begin
      m <= model_step(m);
    end
  end

  // Pulse monitors and per-cycle comparison against the model.
  int   wr_pulses = 0, rd_pulses = 0, inta_pulses = 0, rd_width = 0;
  int   wait_low_all = 0, wait_low_after = 0;
  logic prev_wr = 1'b0, prev_rd = 1'b0, prev_inta = 1'b0, seen = 1'b0;
  logic [7:0] cap_addr = '0, cap_wdata = '0;

  always @(negedge clk) begin
    if (io_wr === 1'b1 && !prev_wr) begin
      wr_pulses <= wr_pulses + 1; cap_addr <= io_addr; cap_wdata <= io_wdata;
    end
    if (io_rd === 1'b1 && !prev_rd) rd_pulses <= rd_pulses + 1;
    if (inta === 1'b1 && !prev_inta) inta_pulses <= inta_pulses + 1;
    if (io_rd === 1'b1) rd_width <= rd_width + 1;
    if (wait_n === 1'b0) wait_low_all <= wait_low_all + 1;
    if (wait_n === 1'b0 && (seen || io_wr === 1'b1 || io_rd === 1'b1))
      wait_low_after <= wait_low_after + 1;
    seen <= iorq_n ? 1'b0 : (seen | (io_wr === 1'b1) | (io_rd === 1'b1));
    prev_wr <= (io_wr === 1'b1); prev_rd <= (io_rd === 1'b1); prev_inta <= (inta === 1'b1);
    if (started) begin
      chk("cpu_di",   16'(cpu_di),   16'(m.di));
      chk("wait_n",   16'(wait_n),   16'(!(!iorq_n && m1_n && m.ph != 2'd3)));
      chk("int_n",    16'(int_n),    16'(m.int_n));
      chk("io_rd",    16'(io_rd),    16'(m.rd));
      chk("io_wr",    16'(io_wr),    16'(m.wr));
      chk("inta",     16'(inta),     16'(m.inta));
      chk("io_addr",  16'(io_addr),  16'(m.addr));
      chk("io_wdata", 16'(io_wdata), 16'(m.wdata));
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic release_bus();
    iorq_n = 1'b1; m1_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1; io_rdy = 1'b0;
  endtask

  task automatic rand_cycle();
    cen      = ($urandom_range(0, 9) < 7);
    io_rdy   = ($urandom_range(0, 3) == 0);
    io_rdata = 8'($urandom);
    int_req  = ($urandom_range(0, 7) == 0);
    int_vec  = 8'($urandom);
  endtask

  int b_wr, b_rd, b_inta, b_width, b_wall, b_wafter, lowcnt;

  task automatic snap();
    b_wr = wr_pulses; b_rd = rd_pulses; b_inta = inta_pulses; b_width = rd_width;
    b_wall = wait_low_all; b_wafter = wait_low_after;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    reset_n = 1'b0; cen = 1'b1; int_req = 1'b1;
    tick(3);
    chk("rst_cpu_di", 16'(cpu_di), 16'h00);
    chk("rst_wait_n", 16'(wait_n), 16'h1);
    chk("rst_int_n",  16'(int_n),  16'h1);
    chk("rst_strobes", 16'({io_rd, io_wr, inta}), 16'h0);
    int_req = 1'b0;
    reset_n = 1'b1;
    tick(2);

    // Write with io_rdy present in the REQ tick
    snap();
    A = 16'h0042; cpu_dout = 8'h5A; iorq_n = 1'b0; wr_n = 1'b0; io_rdy = 1'b1;
    tick(3);
    chk("wr_pulses", 16'(wr_pulses - b_wr), 16'd1);
    chk("wr_addr",   16'(cap_addr), 16'h42);
    chk("wr_wdata",  16'(cap_wdata), 16'h5A);
    chk("wr_wait_low", 16'(wait_low_after - b_wafter), 16'd1);
    chk("wr_no_rd",  16'(rd_pulses - b_rd), 16'd0);
    release_bus();
    tick(2);

    // Read with io_rdy three ticks after io_rd
    snap();
    A = 16'hAB10; iorq_n = 1'b0; rd_n = 1'b0;
    tick(3);
    io_rdy = 1'b1; io_rdata = 8'hC3;
    tick(1);
    io_rdy = 1'b0; io_rdata = 8'h00;
    chk("rd_cpu_di", 16'(cpu_di), 16'hC3);
    chk("rd_wait_n", 16'(wait_n), 16'h1);
    tick(1);
    chk("rd_pulses", 16'(rd_pulses - b_rd), 16'd1);
    chk("rd_wait_low", 16'(wait_low_after - b_wafter), 16'd3);
    chk("rd_addr", 16'(io_addr), 16'h10);
    release_bus();
    tick(2);

    // Peripheral never answers
    snap();
    iorq_n = 1'b0; rd_n = 1'b0;
    if (TMO_EN) begin
      tick(5);
      chk("tmo_wait_before", 16'(wait_n), 16'h0);
      tick(1);
      chk("tmo_wait_after", 16'(wait_n), 16'h1);
      chk("tmo_cpu_di", 16'(cpu_di), 16'hFF);
    end else begin
      lowcnt = 0;
      for (int i = 0; i < 1000; i++) begin
        tick(1);
        if (wait_n == 1'b0) lowcnt++;
      end
      chk("notmo_wait_low", 16'(lowcnt), 16'd1000);
      release_bus();
      tick(2);
      chk("abort_cpu_di", 16'(cpu_di), 16'hC3);
    end
    chk("tmo_rd_pulses", 16'(rd_pulses - b_rd), 16'd1);
    release_bus();
    tick(2);

    // Reset in the middle of a waiting read
    iorq_n = 1'b0; rd_n = 1'b0;
    tick(3);
    reset_n = 1'b0; iorq_n = 1'b1; rd_n = 1'b1;
    tick(1);
    chk("rstmid_wait_n", 16'(wait_n), 16'h1);
    chk("rstmid_cpu_di", 16'(cpu_di), 16'h00);
    reset_n = 1'b1;
    snap();
    tick(5);
    chk("rstmid_no_strobe", 16'((rd_pulses - b_rd) + (wr_pulses - b_wr)), 16'd0);

    // Interrupt acknowledge
    int_req = 1'b1; int_vec = 8'hFF;
    tick(1);
    chk("inta_int_n", 16'(int_n), 16'h0);
    snap();
    m1_n = 1'b0; iorq_n = 1'b0;
    tick(3);
    chk("inta_pulses", 16'(inta_pulses - b_inta), 16'd1);
    chk("inta_cpu_di", 16'(cpu_di), 16'hFF);
    chk("inta_wait_low", 16'(wait_low_all - b_wall), 16'd0);
    chk("inta_no_strobe", 16'((rd_pulses - b_rd) + (wr_pulses - b_wr)), 16'd0);
    release_bus(); int_req = 1'b0;
    tick(2);

    // cen held low for five clocks while the read strobe is out
    snap();
    A = 16'h0077; iorq_n = 1'b0; rd_n = 1'b0;
    tick(1);
    cen = 1'b0;
    tick(5);
    chk("cen_frozen_rd", 16'(io_rd), 16'h1);
    cen = 1'b1;
    tick(1);
    io_rdy = 1'b1; io_rdata = 8'h5A;
    tick(1);
    io_rdy = 1'b0;
    chk("cen_cpu_di", 16'(cpu_di), 16'h5A);
    chk("cen_rd_width", 16'(rd_width - b_width), 16'd6);
    chk("cen_rd_pulses", 16'(rd_pulses - b_rd), 16'd1);
    release_bus();
    tick(2);

    // Randomized bus traffic against the model
    for (int t = 0; t < 150; t++) begin
      int kind, hold;
      bit abort;
      kind = int'($urandom_range(0, 3));
      hold = int'($urandom_range(1, 12));
      abort = ($urandom_range(0, 7) == 0);
      A = 16'($urandom); cpu_dout = 8'($urandom);
      m1_n = (kind != 2);
      wr_n = !(kind == 0 || kind == 3);
      rd_n = !(kind == 1 || kind == 3);
      iorq_n = 1'b0;
      for (int c = 0; c < 60; c++) begin
        rand_cycle();
        tick(1);
        if (c >= hold && (abort || wait_n)) break;
      end
      release_bus();
      for (int k = 0; k < int'($urandom_range(1, 4)); k++) begin
        rand_cycle();
        io_rdy = 1'b0;
        tick(1);
      end
    end
    cen = 1'b1;
    tick(3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/z80_io_bridge.md
Z80_IO_BRIDGE -- requirements
Module: z80_io_bridge

Interface
REQ-001 Parameter TIMEOUT, default 255: maximum clk-enable ticks to wait for io_rdy (1..255).
REQ-002 Parameter OPEN_BUS, default 8'hFF: read data returned on timeout.
REQ-003 Port clk, in, 1: single system clock, rising-edge.
REQ-004 Port reset_n, in, 1: reset, synchronous, active-low.
REQ-005 Port cen, in, 1: clock enable shared with the CPU core; all state advances only when cen=1.
REQ-006 Port m1_n, iorq_n, rd_n, wr_n, in, 1 each: CPU bus strobes, active-low.
REQ-007 Port A, in, 16: CPU address; only A[7:0] is used.
REQ-008 Port cpu_dout, in, 8: CPU write data.
REQ-009 Port cpu_di, out, 8: data returned to the CPU.
REQ-010 Port wait_n, out, 1: wait request to the CPU, active-low.
REQ-011 Port int_n, out, 1: interrupt request to the CPU, active-low.
REQ-012 Port io_addr, io_wdata, out, 8 each: peripheral address/write data, valid while a strobe is high.
REQ-013 Port io_rd, io_wr, out, 1 each: peripheral strobes, high for exactly one cen tick.
REQ-014 Port io_rdy, in, 1; io_rdata, in, 8: peripheral completion and read data.
REQ-015 Port int_req, in, 1; int_vec, in, 8: peripheral interrupt request and vector.
REQ-016 Port inta, out, 1: one-cen-tick pulse when an interrupt acknowledge starts.

Function
REQ-017 FSM states IDLE, REQ, WAIT_RDY, HOLD.
REQ-018 IDLE->REQ on a falling edge of iorq_n (previous registered value 1, current 0) with m1_n=1; io_addr/io_wdata latched from A[7:0]/cpu_dout at that tick.
REQ-019 In REQ, io_wr=1 if wr_n=0, else io_rd=1 if rd_n=0; wr_n and rd_n both low: write wins, no read.
REQ-020 REQ->HOLD if io_rdy=1 in the REQ tick; otherwise REQ->WAIT_RDY.
REQ-021 WAIT_RDY->HOLD on the first tick with io_rdy=1; on reads, io_rdata is captured into cpu_di at that tick.
REQ-022 HOLD->IDLE when iorq_n=1; cpu_di holds its last value thereafter.
REQ-023 wait_n = 0 combinationally whenever iorq_n=0, m1_n=1 and state is not HOLD; otherwise 1. The 1-cycle path to HOLD therefore releases the CPU one tick after io_rdy.
REQ-024 Interrupt acknowledge: iorq_n falling with m1_n=0 pulses inta for one tick, drives cpu_di=int_vec (sampled at that tick), and does not assert wait_n or io strobes.
REQ-025 int_n registered: int_n <= ~int_req each cen tick.
REQ-026 iorq_n rising while in REQ/WAIT_RDY (aborted cycle): return to IDLE, no further strobes, cpu_di unchanged.
REQ-027 io_rdy is ignored in IDLE and HOLD.

Reset
REQ-028 reset_n=0 at a clk edge (regardless of cen): state=IDLE, cpu_di=8'h00, wait_n=1, int_n=1, io_rd=io_wr=inta=0, io_addr=io_wdata=8'h00, timeout counter=0, previous-iorq register=1.
REQ-029 Reset mid-transaction abandons it; no strobe is issued after reset is released until a new iorq_n falling edge.

Configuration
REQ-030 Macro IO_BRIDGE_TIMEOUT_EN defined: an 8-bit counter clears on REQ entry and increments each cen tick in WAIT_RDY. On reaching TIMEOUT: go to HOLD; reads load cpu_di=OPEN_BUS.
REQ-031 Macro undefined: no counter is built; WAIT_RDY waits indefinitely for io_rdy.

Structure
REQ-032 Shared package z80_bus_pkg holds the FSM state typedef and the OPEN_BUS default constant.
REQ-033 Timeout counter is one sub-module, z80_io_timeout, instantiated only under IO_BRIDGE_TIMEOUT_EN.

Verification
REQ-034 Write: A=16'h0042, cpu_dout=8'h5A, iorq_n/wr_n low, io_rdy high at the REQ tick -> exactly one io_wr pulse with io_addr=8'h42, io_wdata=8'h5A; wait_n low for exactly 1 tick.
REQ-035 Read: io_rdy arrives 3 ticks after io_rd with io_rdata=8'hC3 -> wait_n low until HOLD; cpu_di=8'hC3; a single io_rd pulse.
REQ-036 INTA: int_req=1, int_vec=8'hFF; m1_n and iorq_n fall together -> int_n=0 one tick after int_req; one inta pulse; cpu_di=8'hFF; wait_n stays 1; no io strobes.
REQ-037 Timeout, macro on, TIMEOUT=4, io_rdy never asserted -> HOLD after 4 WAIT_RDY ticks; cpu_di=8'hFF; wait_n released. Macro off: wait_n stays low for 1000 ticks.
REQ-038 Reset asserted in WAIT_RDY -> next edge: IDLE, wait_n=1, cpu_di=8'h00; no strobe until a new iorq_n falling edge.
REQ-039 cen held at 0 for 5 clk during a read -> state, strobes and counter frozen; strobe pulse width equals one cen tick.
